// File: rtl/dm_store_buffer.sv
// Posted-write store buffer in front of the 4K data memory: queues stores, drains one per
// free cycle, arbitrates the memory port with loads and stalls loads that hit a pending word.
module dm_store_buffer #(
    parameter int unsigned Depth = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        st_valid_i,
    output logic        st_ready_o,
    input  logic [11:0] st_addr_i,
    input  logic [31:0] st_data_i,
    input  logic        st_byte_i,
    input  logic        ld_req_i,
    input  logic [11:0] ld_addr_i,
    input  logic [1:0]  ld_byte_ext_i,
    output logic        ld_stall_o,
    output logic        empty_o,
    output logic [11:0] dm_addr_o,
    output logic [31:0] dm_din_o,
    output logic [1:0]  dm_byte_ext_o,
    output logic [1:0]  dm_w_en_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [11:0]     addr_q [Depth];
    logic [31:0]     data_q [Depth];
    logic            byte_q [Depth];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW:0]   count_q, count_d;

    logic full;
    logic enq;
    logic drain;
    logic ld_hit;

    assign full       = (count_q == (PtrW+1)'(Depth));
    assign empty_o    = (count_q == '0);
    assign st_ready_o = !full;
    assign enq        = st_valid_i && !full;

    // An entry is live when its distance from the head (modulo Depth) is below the count.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (({1'b0, PtrW'(i) - head_q} < count_q) &&
                (addr_q[i][11:2] == ld_addr_i[11:2])) begin
                ld_hit = ld_req_i;
            end
        end
    end

    always_comb begin
        drain         = 1'b0;
        ld_stall_o    = 1'b0;
        dm_addr_o     = ld_addr_i;
        dm_byte_ext_o = ld_byte_ext_i;
        dm_din_o      = '0;
        dm_w_en_o     = 2'b00;
        if (ld_req_i && !ld_hit && !full) begin
            drain = 1'b0;
        end else if (!empty_o) begin
            // A full buffer drains even under a non-hitting load so stores cannot starve.
            drain         = 1'b1;
            ld_stall_o    = ld_req_i;
            dm_addr_o     = addr_q[head_q];
            dm_din_o      = byte_q[head_q] ? {24'b0, data_q[head_q][7:0]} : data_q[head_q];
            dm_byte_ext_o = byte_q[head_q] ? 2'b10 : 2'b11;
            dm_w_en_o     = 2'b01;
        end
    end

    always_comb begin
        head_d  = drain ? head_q + PtrW'(1) : head_q;
        tail_d  = enq ? tail_q + PtrW'(1) : tail_q;
        count_d = count_q;
        unique case ({enq, drain})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload is not reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr_i;
            data_q[tail_q] <= st_data_i;
            byte_q[tail_q] <= st_byte_i;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios then random traffic against a
// queue-based reference model of the posted-write buffer.
module tb_dm_store_buffer;

    localparam int unsigned Depth = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [11:0] st_addr_i;
    logic [31:0] st_data_i;
    logic        st_byte_i;
    logic        ld_req_i;
    logic [11:0] ld_addr_i;
    logic [1:0]  ld_byte_ext_i;
    logic        ld_stall_o;
    logic        empty_o;
    logic [11:0] dm_addr_o;
    logic [31:0] dm_din_o;
    logic [1:0]  dm_byte_ext_o;
    logic [1:0]  dm_w_en_o;

    dm_store_buffer #(.Depth(Depth)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .st_valid_i   (st_valid_i),
        .st_ready_o   (st_ready_o),
        .st_addr_i    (st_addr_i),
        .st_data_i    (st_data_i),
        .st_byte_i    (st_byte_i),
        .ld_req_i     (ld_req_i),
        .ld_addr_i    (ld_addr_i),
        .ld_byte_ext_i(ld_byte_ext_i),
        .ld_stall_o   (ld_stall_o),
        .empty_o      (empty_o),
        .dm_addr_o    (dm_addr_o),
        .dm_din_o     (dm_din_o),
        .dm_byte_ext_o(dm_byte_ext_o),
        .dm_w_en_o    (dm_w_en_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } store_t;

    store_t      pend[$];
    logic [31:0] mem[1024];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, then update the model.
    task automatic step(input logic sv, input logic [11:0] sa, input logic [31:0] sd,
                        input logic sb, input logic lr, input logic [11:0] la,
                        input logic [1:0] le);
        bit          full, hit, do_drain;
        store_t      s;
        st_valid_i    = sv;
        st_addr_i     = sa;
        st_data_i     = sd;
        st_byte_i     = sb;
        ld_req_i      = lr;
        ld_addr_i     = la;
        ld_byte_ext_i = le;
        #1;
        full = (pend.size() == Depth);
        hit  = 1'b0;
        foreach (pend[i]) if (pend[i].addr[11:2] == la[11:2]) hit = lr;
        do_drain = !(lr && !hit && !full) && (pend.size() != 0);
        chk("st_ready", 32'(st_ready_o), 32'(!full));
        chk("empty", 32'(empty_o), 32'(pend.size() == 0));
        chk("ld_stall", 32'(ld_stall_o), 32'(do_drain && lr));
        chk("dm_w_en", 32'(dm_w_en_o), do_drain ? 32'd1 : 32'd0);
        if (do_drain) begin
            s = pend[0];
            chk("dm_addr", 32'(dm_addr_o), 32'(s.addr));
            chk("dm_din", dm_din_o, s.is_byte ? {24'b0, s.data[7:0]} : s.data);
            chk("dm_byte_ext", 32'(dm_byte_ext_o), s.is_byte ? 32'd2 : 32'd3);
        end else begin
            chk("dm_addr", 32'(dm_addr_o), 32'(la));
            chk("dm_din", dm_din_o, 32'd0);
            chk("dm_byte_ext", 32'(dm_byte_ext_o), 32'(le));
        end
        @(posedge clk_i);
        if (do_drain) begin
            s = pend.pop_front();
            n_writes++;
            if (s.is_byte) mem[s.addr[11:2]][7:0] = s.data[7:0];
            else mem[s.addr[11:2]] = s.data;
        end
        if (sv && !full) pend.push_back('{addr: sa, data: sd, is_byte: sb});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 12'h0, 32'h0, 0, 0, 12'h7F0, 2'b00);
    endtask

    initial begin
        rst_ni        = 1'b0;
        st_valid_i    = 1'b0;
        st_addr_i     = '0;
        st_data_i     = '0;
        st_byte_i     = 1'b0;
        ld_req_i      = 1'b0;
        ld_addr_i     = 12'h2A4;
        ld_byte_ext_i = 2'b01;
        foreach (mem[i]) mem[i] = 32'h0;
        #12;
        chk("rst_st_ready", 32'(st_ready_o), 32'd1);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_ld_stall", 32'(ld_stall_o), 32'd0);
        chk("rst_dm_w_en", 32'(dm_w_en_o), 32'd0);
        chk("rst_dm_din", dm_din_o, 32'd0);
        chk("rst_dm_addr", 32'(dm_addr_o), 32'h2A4);
        chk("rst_dm_byte_ext", 32'(dm_byte_ext_o), 32'd1);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single word store drains the following cycle.
        step(1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h000, 2'b00);
        idle(2);
        chk("mem_word4", mem[4], 32'hDEADBEEF);

        // Fill under non-hitting loads; the full buffer then drains despite the load.
        for (int i = 0; i < 4; i++)
            step(1, 12'h100 + 12'(4 * i), 32'hA0 + 32'(i), 0, 1, 12'h200, 2'b11);
        chk("full_st_ready", 32'(st_ready_o), 32'd0);
        step(0, 12'h0, 32'h0, 0, 1, 12'h200, 2'b11);
        idle(4);

        // Byte store then a load to the same word stalls for the drain.
        step(1, 12'h013, 32'h123456AB, 1, 0, 12'h000, 2'b00);
        step(0, 12'h0, 32'h0, 0, 1, 12'h010, 2'b11);
        step(0, 12'h0, 32'h0, 0, 1, 12'h010, 2'b11);
        chk("mem_byte_lane", mem[4], 32'hDEADBEAB);

        // Hold two entries in flight across the pointer wrap.
        step(1, 12'h020, 32'h11111111, 0, 1, 12'h300, 2'b00);
        step(1, 12'h024, 32'h22222222, 0, 1, 12'h300, 2'b00);
        for (int i = 0; i < 5; i++)
            step(1, 12'h030 + 12'(4 * i), 32'h33330000 + 32'(i), 0, 0, 12'h0, 2'b00);
        idle(3);

        // One pending entry waits out continuous non-hitting loads.
        step(1, 12'h040, 32'hCAFEF00D, 0, 1, 12'h400, 2'b10);
        for (int i = 0; i < 4; i++) step(0, 12'h0, 32'h0, 0, 1, 12'h404 + 12'(4 * i), 2'b10);
        step(0, 12'h0, 32'h0, 0, 0, 12'h0, 2'b00);
        chk("mem_word16", mem[16], 32'hCAFEF00D);

        // Asynchronous reset mid-drain discards pending stores.
        for (int i = 0; i < 3; i++)
            step(1, 12'h050 + 12'(4 * i), 32'h5 + 32'(i), 0, 1, 12'h600, 2'b00);
        ld_req_i = 1'b0;
        #2;
        chk("pre_rst_w_en", 32'(dm_w_en_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_empty", 32'(empty_o), 32'd1);
        chk("async_rst_w_en", 32'(dm_w_en_o), 32'd0);
        chk("async_rst_st_ready", 32'(st_ready_o), 32'd1);
        pend.delete();
        @(posedge clk_i);
        #1;
        chk("rst_edge_w_en", 32'(dm_w_en_o), 32'd0);
        rst_ni = 1'b1;
        idle(2);

        // Random traffic over a handful of words to exercise hits and wraps.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 9) < 6), 12'($urandom) & 12'h01F, $urandom,
                 1'($urandom), 1'($urandom_range(0, 9) < 6), 12'($urandom) & 12'h01F,
                 2'($urandom));
        idle(6);
        chk("final_empty", 32'(empty_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
